// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT front end: states, source encodings,
// built-in test frame and the index bit-reversal helper.
package fft_pkg;

  // Frame geometry shared with the FFT core and the result-display sequencer.
  localparam int FFT_N = 8;
  localparam int FFT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // sel encodings; any value with bit 1 set selects the built-in test frame.
  typedef enum logic [1:0] {
    SRC_BANK0 = 2'b00,
    SRC_BANK1 = 2'b01,
    SRC_TEST  = 2'b10
  } src_e;

  // Test frame: (1.0, 0) in slot 0, (1.5, 0) in slot 1, zeros elsewhere.
  localparam logic [31:0] TEST_SLOT0 = 32'h0100_0000;
  localparam logic [31:0] TEST_SLOT1 = 32'h0180_0000;

  function automatic logic is_test(input logic [1:0] src);
    return src[1];
  endfunction

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(bits)) begin
        r = r | (((v >> i) & 32'd1) << (bits - 1 - i));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rd_lat_pipe.sv
// Delay line of {valid, index} matching the memory read latency, so each
// returning read word arrives together with the slot it belongs to.
module fft_rd_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [IW-1:0] in_index,
  output logic          out_valid,
  output logic [IW-1:0] out_index
);

  logic          valid_q [DEPTH];
  logic [IW-1:0] index_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            valid_q[gi] <= 1'b0;
            index_q[gi] <= '0;
          end else begin
            valid_q[gi] <= in_valid;
            index_q[gi] <= in_index;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (reset) begin
            valid_q[gi] <= 1'b0;
            index_q[gi] <= '0;
          end else begin
            valid_q[gi] <= valid_q[gi-1];
            index_q[gi] <= index_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = valid_q[DEPTH-1];
  assign out_index = index_q[DEPTH-1];

endmodule

// File: rtl/fft_input_loader.sv
// Loads one N-sample complex frame from memory (or a built-in test frame) into
// a register bank and offers it to the FFT core. FFT_LOADER_BITREV_EN stores
// address k in slot bitrev(k) instead of slot k.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int W      = FFT_W,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           sel,
  output logic                 mem_en,
  output logic                 mem_bank,
  output logic [$clog2(N)-1:0] mem_addr,
  input  logic [W-1:0]         mem_dout,
  output logic [N*W-1:0]       samples,
  output logic                 samples_valid,
  input  logic                 samples_ready,
  output logic                 busy
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(RD_LAT + 1) + 1;

  state_e          state_q;
  logic [1:0]      src_q;
  logic [AW-1:0]   addr_q;
  logic            mem_en_q;
  logic            bank_q;
  logic            valid_q;
  logic            busy_q;
  logic [CW-1:0]   dcnt_q;

  logic            launch;
  logic            issue_act;
  logic            cap_valid;
  logic [AW-1:0]   cap_index;
  logic [AW-1:0]   slot_idx;
  logic [W-1:0]    sample_d;
  logic [W-1:0]    samples_q [N];

  // A start is honoured only when no frame is in flight.
  assign launch    = start && ((state_q == IDLE) || (state_q == HOLD));
  assign issue_act = (state_q == ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= 2'b00;
      addr_q   <= '0;
      mem_en_q <= 1'b0;
      bank_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dcnt_q   <= '0;
    end else if (launch) begin
      state_q  <= ISSUE;
      src_q    <= sel;
      bank_q   <= sel[0];
      addr_q   <= '0;
      mem_en_q <= (sel == SRC_BANK0) || (sel == SRC_BANK1);
      busy_q   <= 1'b1;
      valid_q  <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      case (state_q)
        ISSUE: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == AW'(N - 1)) begin
            state_q  <= DRAIN;
            mem_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          // Extra cycle after the last capture so valid rises on a settled bank.
          if (dcnt_q == CW'(RD_LAT)) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (samples_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  fft_rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .IW    (AW)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_act),
    .in_index  (addr_q),
    .out_valid (cap_valid),
    .out_index (cap_index)
  );

  always_comb begin
    slot_idx = cap_index;
`ifdef FFT_LOADER_BITREV_EN
    slot_idx = AW'(bitrev(32'(cap_index), AW));
`endif
    sample_d = mem_dout;
    if (is_test(src_q)) begin
      sample_d = '0;
      if (cap_index == AW'(0)) sample_d = W'(TEST_SLOT0);
      if (cap_index == AW'(1)) sample_d = W'(TEST_SLOT1);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          samples_q[gi] <= '0;
        end else if (cap_valid && !valid_q && (slot_idx == AW'(gi))) begin
          samples_q[gi] <= sample_d;
        end
      end
      assign samples[gi*W +: W] = samples_q[gi];
    end
  endgenerate

  assign mem_en        = mem_en_q;
  assign mem_bank      = bank_q;
  assign mem_addr      = addr_q;
  assign samples_valid = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: one RD_LAT=1 instance and one RD_LAT=3
// instance, each fed by a latency-matched two-bank memory model.
module tb_fft_input_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start1, ready1, mem_en1, bank1, valid1, busy1;
  logic [1:0]   sel1;
  logic [2:0]   addr1;
  logic [31:0]  dout1;
  logic [255:0] samples1;
  logic         start2, ready2, mem_en2, bank2, valid2, busy2;
  logic [1:0]   sel2;
  logic [2:0]   addr2;
  logic [31:0]  dout2;
  logic [255:0] samples2;

  logic [31:0] mem0 [8];
  logic [31:0] mem1 [8];

  int total = 0;
  int bad   = 0;

  fft_input_loader #(.N(8), .W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sel(sel1),
    .mem_en(mem_en1), .mem_bank(bank1), .mem_addr(addr1), .mem_dout(dout1),
    .samples(samples1), .samples_valid(valid1), .samples_ready(ready1), .busy(busy1)
  );

  fft_input_loader #(.N(8), .W(32), .RD_LAT(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .sel(sel2),
    .mem_en(mem_en2), .mem_bank(bank2), .mem_addr(addr2), .mem_dout(dout2),
    .samples(samples2), .samples_valid(valid2), .samples_ready(ready2), .busy(busy2)
  );

  // Memory models: data appears RD_LAT cycles after the enabled address.
  logic [31:0] p1, p2a, p2b, p2c;
  always @(posedge clk) begin
    p1  <= mem_en1 ? (bank1 ? mem1[addr1] : mem0[addr1]) : 32'hBAD0_BAD0;
    p2a <= mem_en2 ? (bank2 ? mem1[addr2] : mem0[addr2]) : 32'hBAD0_BAD0;
    p2b <= p2a;
    p2c <= p2b;
  end
  assign dout1 = p1;
  assign dout2 = p2c;

  int   reads1 = 0;
  int   rises1 = 0;
  logic valid1_d = 1'b0;
  always @(posedge clk) begin
    valid1_d <= valid1;
    if (mem_en1) reads1 <= reads1 + 1;
    if (valid1 && !valid1_d) rises1 <= rises1 + 1;
  end

  function automatic int map(input int k);
`ifdef FFT_LOADER_BITREV_EN
    case (k)
      0: return 0;
      1: return 4;
      2: return 2;
      3: return 6;
      4: return 1;
      5: return 5;
      6: return 3;
      default: return 7;
    endcase
`else
    return k;
`endif
  endfunction

  task automatic launch1(input logic [1:0] s);
    @(negedge clk);
    sel1   = s;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  // Counts edges until valid; lat=99 marks an expired bound.
  task automatic wait_valid(input int which, output int lat, output bit gap);
    lat = 99;
    gap = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if ((which == 1) ? valid1 : valid2) begin
        lat = n;
        break;
      end
      if (!((which == 1) ? busy1 : busy2)) gap = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; sel1 = 2'b00; ready1 = 1'b0;
    start2 = 1'b0; sel2 = 2'b00; ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid1, busy1, mem_en1, bank1, addr1} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl got v=%b b=%b en=%b bank=%b addr=%0d want all 0",
               valid1, busy1, mem_en1, bank1, addr1);
    end
    total++;
    if (samples1 !== 256'd0) begin
      bad++;
      $display("FAIL reset_samples got=%h want=0", samples1);
    end
    total++;
    if ({valid2, busy2, mem_en2} !== 3'd0) begin
      bad++;
      $display("FAIL reset_dut2 got v=%b b=%b en=%b want 0", valid2, busy2, mem_en2);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_bank0();
    int lat; bit gap; int r0; logic [255:0] ev; bit stable;
    for (int k = 0; k < 8; k++) begin
      mem0[k] = k * 32'h0001_0001;
      mem1[k] = 32'h5555_0000 | k;
    end
    ev = '0;
    for (int k = 0; k < 8; k++) ev[map(k)*32 +: 32] = k * 32'h0001_0001;
    r0 = reads1;
    launch1(2'b00);
    wait_valid(1, lat, gap);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL bank0_latency got=%0d want=10", lat); end
    total++;
    if (gap !== 1'b0) begin bad++; $display("FAIL bank0_busy got gap=%b want 0", gap); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (samples1[k*32 +: 32] !== ev[k*32 +: 32]) begin
        bad++;
        $display("FAIL bank0_slot%0d got=%h want=%h", k, samples1[k*32 +: 32], ev[k*32 +: 32]);
      end
    end
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (samples1 !== ev || valid1 !== 1'b1) stable = 1'b0;
    end
    total++;
    if (!stable) begin bad++; $display("FAIL bank0_hold got unstable want stable"); end
    total++;
    if (reads1 - r0 !== 8) begin bad++; $display("FAIL bank0_reads got=%0d want=8", reads1 - r0); end
    $display("test_bank0: latency=%0d", lat);
  endtask

  task automatic test_handshake();
    @(negedge clk);
    ready1 = 1'b1;
    @(posedge clk);
    #1;
    ready1 = 1'b0;
    total++;
    if ({valid1, busy1, mem_en1} !== 3'b000) begin
      bad++;
      $display("FAIL handshake_drop got v=%b b=%b en=%b want 000", valid1, busy1, mem_en1);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid1, busy1} !== 2'b00) begin
      bad++;
      $display("FAIL handshake_idle got v=%b b=%b want 00", valid1, busy1);
    end
    $display("test_handshake: done");
  endtask

  task automatic test_test_frame();
    int lat; bit gap; int r0; logic [255:0] ev;
    ev = '0;
    ev[map(0)*32 +: 32] = 32'h0100_0000;
    ev[map(1)*32 +: 32] = 32'h0180_0000;
    r0 = reads1;
    launch1(2'b10);
    wait_valid(1, lat, gap);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL tframe_latency got=%0d want=10", lat); end
    total++;
    if (reads1 - r0 !== 0) begin bad++; $display("FAIL tframe_reads got=%0d want=0", reads1 - r0); end
    total++;
    if (samples1 !== ev) begin bad++; $display("FAIL tframe_samples got=%h want=%h", samples1, ev); end
    @(negedge clk); ready1 = 1'b1;
    @(posedge clk); #1; ready1 = 1'b0;
    $display("test_test_frame: latency=%0d", lat);
  endtask

  task automatic test_start_ignored();
    int lat; int r0; int rs0; logic bankchk; logic [255:0] ev;
    ev = '0;
    for (int k = 0; k < 8; k++) ev[map(k)*32 +: 32] = k * 32'h0001_0001;
    r0 = reads1; rs0 = rises1; lat = 99; bankchk = 1'b1;
    launch1(2'b00);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (valid1 && lat == 99) lat = n;
      if (n == 4) bankchk = bank1;
      start1 = (n == 2) || (n == 5);
      if (n == 2) sel1 = 2'b01;
    end
    start1 = 1'b0;
    total++;
    if (lat !== 10) begin bad++; $display("FAIL ign_latency got=%0d want=10", lat); end
    total++;
    if (reads1 - r0 !== 8) begin bad++; $display("FAIL ign_reads got=%0d want=8", reads1 - r0); end
    total++;
    if (rises1 - rs0 !== 1) begin bad++; $display("FAIL ign_rises got=%0d want=1", rises1 - rs0); end
    total++;
    if (bankchk !== 1'b0) begin bad++; $display("FAIL ign_bank got=%b want=0", bankchk); end
    total++;
    if (samples1 !== ev) begin bad++; $display("FAIL ign_samples got=%h want=%h", samples1, ev); end
    @(negedge clk); ready1 = 1'b1;
    @(posedge clk); #1; ready1 = 1'b0;
    $display("test_start_ignored: latency=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat; bit gap; logic [255:0] ev;
    for (int k = 0; k < 8; k++) mem0[k] = 32'hA0A0_0000 + k;
    ev = '0;
    for (int k = 0; k < 8; k++) ev[map(k)*32 +: 32] = 32'hA0A0_0000 + k;
    launch1(2'b00);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if ({valid1, busy1, mem_en1, bank1, addr1} !== 7'd0) begin
      bad++;
      $display("FAIL rstmid_ctrl got v=%b b=%b en=%b bank=%b addr=%0d want all 0",
               valid1, busy1, mem_en1, bank1, addr1);
    end
    total++;
    if (samples1 !== 256'd0) begin bad++; $display("FAIL rstmid_samples got=%h want=0", samples1); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid1, busy1} !== 2'b00) begin bad++; $display("FAIL rstmid_idle got v=%b b=%b want 00", valid1, busy1); end
    launch1(2'b00);
    wait_valid(1, lat, gap);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL rstmid_latency got=%0d want=10", lat); end
    total++;
    if (samples1 !== ev) begin bad++; $display("FAIL rstmid_reload got=%h want=%h", samples1, ev); end
    $display("test_reset_mid: latency=%0d", lat);
  endtask

  task automatic test_restart();
    int lat; bit gap; logic [255:0] ev;
    ev = '0;
    ev[map(0)*32 +: 32] = 32'h0100_0000;
    ev[map(1)*32 +: 32] = 32'h0180_0000;
    @(negedge clk);
    sel1 = 2'b10; start1 = 1'b1; ready1 = 1'b0;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    total++;
    if ({valid1, busy1} !== 2'b01) begin bad++; $display("FAIL restart_drop got v=%b b=%b want 01", valid1, busy1); end
    wait_valid(1, lat, gap);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL restart_latency got=%0d want=10", lat); end
    total++;
    if (samples1 !== ev) begin bad++; $display("FAIL restart_samples got=%h want=%h", samples1, ev); end
    @(negedge clk); ready1 = 1'b1;
    @(posedge clk); #1; ready1 = 1'b0;
    $display("test_restart: latency=%0d", lat);
  endtask

  task automatic test_bank1_lat3();
    int lat; bit gap; logic [255:0] ev; logic [31:0] want1;
    for (int k = 0; k < 8; k++) mem1[k] = 32'h1000_0000 + k;
    mem1[7] = 32'hDEAD_BEEF;
    ev = '0;
    for (int k = 0; k < 8; k++) ev[map(k)*32 +: 32] = mem1[k];
`ifdef FFT_LOADER_BITREV_EN
    want1 = 32'h1000_0004;
`else
    want1 = 32'h1000_0001;
`endif
    @(negedge clk);
    sel2 = 2'b01; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    wait_valid(2, lat, gap);
    total++;
    if (lat !== 12) begin bad++; $display("FAIL lat3_latency got=%0d want=12", lat); end
    total++;
    if (bank2 !== 1'b1) begin bad++; $display("FAIL lat3_bank got=%b want=1", bank2); end
    total++;
    if (samples2[7*32 +: 32] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL lat3_slot7 got=%h want=deadbeef", samples2[7*32 +: 32]);
    end
    total++;
    if (samples2[1*32 +: 32] !== want1) begin
      bad++; $display("FAIL lat3_slot1 got=%h want=%h", samples2[1*32 +: 32], want1);
    end
    total++;
    if (samples2 !== ev) begin bad++; $display("FAIL lat3_samples got=%h want=%h", samples2, ev); end
    $display("test_bank1_lat3: latency=%0d", lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      mem0[k] = '0;
      mem1[k] = '0;
    end
    test_reset();
    test_bank0();
    test_handshake();
    test_test_frame();
    test_start_ignored();
    test_reset_mid();
    test_restart();
    test_bank1_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
